// File: rtl/exc_pkg.sv
// exc_pkg: shared definitions for the exception controller.
//   state_t          controller state (IDLE, FLUSH, HANDLER)
//   CAUSE_*          cause codes; the code equals the source bit index
//   EXC_VECTOR_ADDR  default handler entry address
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam int unsigned CAUSE_OVF  = 0;  // arithmetic overflow
  localparam int unsigned CAUSE_ADDR = 1;  // invalid address
  localparam int unsigned CAUSE_DIV0 = 2;  // divide by zero
  localparam int unsigned CAUSE_CTRL = 3;  // illegal control
  localparam int unsigned CAUSE_WR0  = 4;  // write to $0

  localparam logic [31:0] EXC_VECTOR_ADDR = 32'h0000_0080;

endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: combinational lowest-index-first priority encoder.
//   req      in   NUM_SRC  request vector, bit 0 has the highest priority
//   idx      out  CAUSE_W  index of the lowest set bit of req (0 when none)
//   any_req  out  1        at least one bit of req is set
module exc_prio_enc #(
  parameter int NUM_SRC = 5,
  parameter int CAUSE_W = 3
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [CAUSE_W-1:0] idx,
  output logic               any_req
);

  always_comb begin
    // NOTE: idx gets a default before the loop so every path assigns it;
    // without it this block would infer a latch.
    idx = '0;
    // Scan from the top down so the lowest set index is the last write.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = CAUSE_W'(i);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/exception_controller.sv
// exception_controller: registered exception prioritisation, EPC/cause
// capture, flush pulse and handler-busy tracking.
//   clk          in   1        system clock, rising edge
//   rst          in   1        synchronous reset, active-high
//   ex_valid     in   1        instruction in the checking stage is valid
//   ex_req       in   NUM_SRC  per-source exception request
//   ex_pc        in   PC_W     PC of the instruction in the checking stage
//   mask_we      in   1        mask register write enable
//   mask_wdata   in   NUM_SRC  new mask (1 disables a source)
//   eret         in   1        return-from-exception strobe
//   ex_flag      out  1        one-cycle flush/redirect pulse
//   redirect_pc  out  PC_W     VECTOR_ADDR during ex_flag, otherwise epc
//   epc          out  PC_W     PC of the last taken exception
//   cause        out  CAUSE_W  index of the last taken source
//   busy         out  1        controller is in FLUSH or HANDLER
//   lost_vec     out  NUM_SRC  sticky OR of requests dropped while busy
//   drop_cnt     out  DROP_W   saturating count of cycles with a dropped request
//   mask         out  NUM_SRC  current mask register
module exception_controller
  import exc_pkg::*;
#(
  parameter int                  NUM_SRC     = 5,
  parameter int                  PC_W        = 32,
  parameter int                  CAUSE_W     = 3,
  parameter int                  DROP_W      = 4,
  parameter logic [NUM_SRC-1:0]  MASK_RST    = '0,
  parameter logic [PC_W-1:0]     VECTOR_ADDR = PC_W'(EXC_VECTOR_ADDR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [NUM_SRC-1:0] ex_req,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               eret,
  output logic               ex_flag,
  output logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               busy,
  output logic [NUM_SRC-1:0] lost_vec,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic [NUM_SRC-1:0] mask
);

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_t             state, state_next;
  logic [NUM_SRC-1:0] masked_req;
  logic [CAUSE_W-1:0] first_idx;
  logic               any_masked;
  logic               hit;

  // The registered mask is used, so a same-cycle mask write only affects
  // the following cycle.
  assign masked_req = ex_req & ~mask;

  exc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .CAUSE_W (CAUSE_W)
  ) u_prio (
    .req     (masked_req),
    .idx     (first_idx),
    .any_req (any_masked)
  );

  assign hit = ex_valid & any_masked;

  always_comb begin
    state_next  = state;
    ex_flag     = 1'b0;
    busy        = 1'b1;
    redirect_pc = epc;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (hit) state_next = FLUSH;
      end
      FLUSH: begin
        ex_flag     = 1'b1;
        redirect_pc = VECTOR_ADDR;
        state_next  = HANDLER;
      end
      HANDLER: begin
        if (eret) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all state updates use non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= IDLE;
      epc      <= '0;
      cause    <= '0;
      lost_vec <= '0;
      drop_cnt <= '0;
      mask     <= MASK_RST;
    end else begin
      state <= state_next;
      if (mask_we) mask <= mask_wdata;

      if (state == IDLE && hit) begin
        epc   <= ex_pc;
        cause <= first_idx;
      end

      // Returning from the handler clears the log; a hit in that same
      // cycle is dropped and its count vanishes with the clear.
      if (state == HANDLER && eret) begin
        lost_vec <= '0;
        drop_cnt <= '0;
      end else if (state != IDLE && hit) begin
        lost_vec <= lost_vec | masked_req;
        if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exception_controller.sv
// Randomised + directed bench for exception_controller. A behavioural model
// tracks the expected architectural state; every predicted taken exception
// is queued and matched against the DUT's ex_flag pulse by a monitor.
module tb_exception_controller;

  localparam int          NS   = 5;
  localparam int          PW   = 32;
  localparam int          CW   = 3;
  localparam int          DW   = 4;
  localparam logic [4:0]  MRST = 5'b00000;
  localparam logic [31:0] VEC  = 32'h0000_0080;

  logic          clk, rst, ex_valid, mask_we, eret;
  logic [NS-1:0] ex_req, mask_wdata;
  logic [PW-1:0] ex_pc;
  logic          ex_flag, busy;
  logic [PW-1:0] redirect_pc, epc;
  logic [CW-1:0] cause;
  logic [NS-1:0] lost_vec, mask;
  logic [DW-1:0] drop_cnt;

  exception_controller #(
    .NUM_SRC     (NS),
    .PC_W        (PW),
    .CAUSE_W     (CW),
    .DROP_W      (DW),
    .MASK_RST    (MRST),
    .VECTOR_ADDR (VEC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_req      (ex_req),
    .ex_pc       (ex_pc),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .eret        (eret),
    .ex_flag     (ex_flag),
    .redirect_pc (redirect_pc),
    .epc         (epc),
    .cause       (cause),
    .busy        (busy),
    .lost_vec    (lost_vec),
    .drop_cnt    (drop_cnt),
    .mask        (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  cause;
  } flag_exp_t;

  flag_exp_t   exp_q[$];

  // Model: phase 0 = idle, 1 = flush pulse cycle, 2 = in handler.
  int          m_phase = 0;
  logic [31:0] m_epc   = '0;
  logic [2:0]  m_cause = '0;
  logic [4:0]  m_lost  = '0;
  int          m_drop  = 0;
  logic [4:0]  m_mask  = MRST;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_log(input logic [4:0] eff);
    if (eff != 5'b0) begin
      m_lost |= eff;
      if (m_drop < 15) m_drop++;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then return just after
  // the edge that consumed them.
  task automatic step(input logic r, input logic v, input logic [4:0] req,
                      input logic [31:0] pc, input logic mwe, input logic [4:0] mwd,
                      input logic er);
    logic [4:0] eff, lsb;
    @(negedge clk);
    rst = r; ex_valid = v; ex_req = req; ex_pc = pc;
    mask_we = mwe; mask_wdata = mwd; eret = er;
    if (r) begin
      m_phase = 0; m_epc = '0; m_cause = '0; m_lost = '0; m_drop = 0; m_mask = MRST;
    end else begin
      eff = v ? (req & ~m_mask) : 5'b0;
      case (m_phase)
        0: if (eff != 5'b0) begin
          lsb     = eff & (~eff + 5'd1);       // isolate lowest set bit
          m_cause = 3'($countones(lsb - 5'd1));
          m_epc   = pc;
          m_phase = 1;
          exp_q.push_back('{pc: pc, cause: m_cause});
        end
        1: begin
          m_phase = 2;
          model_log(eff);
        end
        default: begin
          if (er) begin
            m_phase = 0; m_lost = '0; m_drop = 0;
          end else model_log(eff);
        end
      endcase
      if (mwe) m_mask = mwd;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'b0, 32'h0, 1'b0, 5'b0, 1'b0);
  endtask

  // Monitor: compare the whole visible state against the model after every
  // edge, and match each flush pulse against the queued prediction.
  initial begin
    flag_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check("ex_flag",     64'(ex_flag),     64'(m_phase == 1));
        check("busy",        64'(busy),        64'(m_phase != 0));
        check("epc",         64'(epc),         64'(m_epc));
        check("cause",       64'(cause),       64'(m_cause));
        check("lost_vec",    64'(lost_vec),    64'(m_lost));
        check("drop_cnt",    64'(drop_cnt),    64'(m_drop));
        check("mask",        64'(mask),        64'(m_mask));
        check("redirect_pc", 64'(redirect_pc), 64'((m_phase == 1) ? VEC : m_epc));
        if (ex_flag === 1'b1) begin
          check("flag_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("flag_epc",   64'(epc),   64'(e.pc));
            check("flag_cause", 64'(cause), 64'(e.cause));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_req = '0; ex_pc = '0;
    mask_we = 1'b0; mask_wdata = '0; eret = 1'b0;

    step(1'b1, 1'b0, 5'b0, 32'h0, 1'b0, 5'b0, 1'b0);
    mon_en = 1'b1;
    step(1'b1, 1'b1, 5'b11111, 32'hdead_beec, 1'b0, 5'b0, 1'b0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mask", 64'(mask), 64'(MRST));
    check("rst_epc",  64'(epc),  64'd0);

    // Basic take: div-by-zero.
    step(1'b0, 1'b1, 5'b00100, 32'h0040_0010, 1'b0, 5'b0, 1'b0);
    check("take_flag",     64'(ex_flag),     64'd1);
    check("take_redirect", 64'(redirect_pc), 64'h80);
    check("take_cause",    64'(cause),       64'd2);
    idle();
    check("handler_flag", 64'(ex_flag), 64'd0);
    check("handler_busy", 64'(busy),    64'd1);
    check("handler_epc",  64'(epc),     64'h0040_0010);
    step(1'b0, 1'b0, 5'b0, 32'h0, 1'b0, 5'b0, 1'b1);
    check("eret_busy", 64'(busy), 64'd0);

    // Priority: lowest index wins.
    step(1'b0, 1'b1, 5'b10110, 32'h0000_0100, 1'b0, 5'b0, 1'b0);
    check("prio_cause", 64'(cause), 64'd1);
    idle();
    check("prio_flag_once", 64'(ex_flag), 64'd0);
    step(1'b0, 1'b0, 5'b0, 32'h0, 1'b0, 5'b0, 1'b1);

    // Mask behaviour and same-cycle mask write.
    step(1'b0, 1'b0, 5'b0, 32'h0, 1'b1, 5'b00001, 1'b0);
    step(1'b0, 1'b1, 5'b00001, 32'h0000_0200, 1'b0, 5'b0, 1'b0);
    check("masked_no_flag", 64'(ex_flag), 64'd0);
    step(1'b0, 1'b1, 5'b00001, 32'h0000_0200, 1'b1, 5'b00000, 1'b0);
    check("mask_we_same_cycle", 64'(ex_flag), 64'd0);
    step(1'b0, 1'b1, 5'b00001, 32'h0000_0200, 1'b0, 5'b0, 1'b0);
    check("unmasked_flag",  64'(ex_flag), 64'd1);
    check("unmasked_cause", 64'(cause),   64'd0);

    // Saturation of the dropped counter.
    idle();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 5'b01000, 32'h0000_0abc, 1'b0, 5'b0, 1'b0);
    check("sat_drop", 64'(drop_cnt), 64'd15);
    check("sat_lost", 64'(lost_vec), 64'b01000);
    check("sat_epc",  64'(epc),      64'h0000_0200);
    step(1'b0, 1'b0, 5'b0, 32'h0, 1'b0, 5'b0, 1'b1);
    check("ret_drop", 64'(drop_cnt), 64'd0);
    check("ret_lost", 64'(lost_vec), 64'd0);

    // eret in IDLE, then hit coincident with eret, then hit right after.
    step(1'b0, 1'b0, 5'b0, 32'h0, 1'b0, 5'b0, 1'b1);
    check("eret_idle_busy", 64'(busy), 64'd0);
    step(1'b0, 1'b1, 5'b00010, 32'h0000_0300, 1'b0, 5'b0, 1'b0);
    idle();
    step(1'b0, 1'b1, 5'b00001, 32'h0000_0400, 1'b0, 5'b0, 1'b1);
    check("eret_hit_flag", 64'(ex_flag),  64'd0);
    check("eret_hit_drop", 64'(drop_cnt), 64'd0);
    check("eret_hit_epc",  64'(epc),      64'h0000_0300);
    step(1'b0, 1'b1, 5'b10000, 32'h0000_0304, 1'b0, 5'b0, 1'b0);
    check("after_ret_flag",  64'(ex_flag), 64'd1);
    check("after_ret_cause", 64'(cause),   64'd4);

    // Reset in the middle of the handler.
    idle();
    step(1'b0, 1'b1, 5'b01000, 32'h0, 1'b1, 5'b10101, 1'b0);
    step(1'b1, 1'b1, 5'b00001, 32'h0000_0500, 1'b0, 5'b0, 1'b1);
    check("midrst_busy", 64'(busy),     64'd0);
    check("midrst_epc",  64'(epc),      64'd0);
    check("midrst_mask", 64'(mask),     64'(MRST));
    check("midrst_drop", 64'(drop_cnt), 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 3) != 0),
           5'($urandom()) & 5'($urandom()),
           $urandom() & 32'hffff_fffc,
           1'($urandom_range(0, 7) == 0),
           5'($urandom()) & 5'($urandom()),
           1'($urandom_range(0, 3) == 0));
    end

    idle();
    idle();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Parametrised, registered successor to the combinational exception flag logic in the MIPS datapath.
- Accepts NUM_SRC per-instruction exception requests and applies a writable mask.
- Prioritises the unmasked requests, then captures EPC and a cause code.
- Drives a one-cycle flush/redirect pulse and holds a handler-busy state until ERET. Requests arriving while busy are logged, not taken.

Parameters:
NUM_SRC, 5, number of exception sources; bit 0 is highest priority (0 overflow, 1 invalid addr, 2 div-by-zero, 3 illegal control, 4 write to $0)
PC_W, 32, width of PC/EPC
CAUSE_W, 3, cause code width; must satisfy 2**CAUSE_W >= NUM_SRC
DROP_W, 4, width of the saturating dropped-exception counter
MASK_RST, 0, reset value of the mask register (0 = all sources enabled)
VECTOR_ADDR, 32'h0000_0080, handler entry address driven on redirect_pc

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
ex_valid  in  1  instruction in the checking stage is valid
ex_req  in  NUM_SRC  per-source exception request, sampled only when ex_valid=1
ex_pc  in  PC_W  PC of the instruction in the checking stage
mask_we  in  1  write enable for the mask register
mask_wdata  in  NUM_SRC  new mask; a 1 disables that source
eret  in  1  return-from-exception strobe
ex_flag  out  1  one-cycle flush/redirect pulse
redirect_pc  out  PC_W  VECTOR_ADDR while ex_flag=1, otherwise epc
epc  out  PC_W  PC of the last taken exception
cause  out  CAUSE_W  index of the last taken source
busy  out  1  controller is in FLUSH or HANDLER
lost_vec  out  NUM_SRC  sticky OR of requests dropped while busy
drop_cnt  out  DROP_W  saturating count of cycles with a dropped request
mask  out  NUM_SRC  current mask register

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; ex_flag=0, busy=0.
  - epc=0, cause=0, lost_vec=0, drop_cnt=0, mask=MASK_RST.
  - Reset overrides every other input in the same cycle, including mid-HANDLER.
- Effective request: hit = ex_valid & |(ex_req & ~mask). The mask used is the register value; a mask_we in the same cycle takes effect the following cycle.
- State machine:
  - IDLE, hit at edge N:
    - at N+1: state=FLUSH, ex_flag=1, epc=ex_pc, cause=index of lowest set bit of (ex_req & ~mask).
    - ex_flag is high for exactly one cycle; latency is 1 cycle from request to flag.
  - FLUSH: unconditionally goes to HANDLER on the next edge; ex_flag=0 from then on.
  - HANDLER: busy=1; eret moves the state to IDLE on the next edge. A hit in the same cycle as eret is dropped. A hit in the first IDLE cycle after the return is taken.
  - eret in IDLE or FLUSH is ignored; no state change and no error.
- Logging while busy (state FLUSH or HANDLER):
  - any hit ORs (ex_req & ~mask) into lost_vec;
  - drop_cnt increments by 1 and saturates at 2**DROP_W-1.
  - epc and cause are not disturbed.
- eret taken from HANDLER clears lost_vec and drop_cnt on the same edge as the return to IDLE.
- ex_req bits with ex_valid=0 never have any effect.
- epc and cause hold their values until the next taken exception.
- mask_we updates mask in any state.

Decomposition:
- Shared package exc_pkg:
  - state enum {IDLE, FLUSH, HANDLER};
  - cause code localparams CAUSE_OVF=0, CAUSE_ADDR=1, CAUSE_DIV0=2, CAUSE_CTRL=3, CAUSE_WR0=4;
  - default VECTOR_ADDR.
- One sub-module, exc_prio_enc: parametrised lowest-index-first priority encoder. Inputs NUM_SRC bits; outputs CAUSE_W index plus an any flag. Purely combinational.

Test Plan:
- Reset then ex_valid=1, ex_req=5'b00100, ex_pc=32'h0040_0010 -> next cycle ex_flag=1, redirect_pc=32'h80, then epc=32'h0040_0010, cause=2, busy=1 held.
- ex_req=5'b10110 in IDLE -> cause=1 (lowest index wins); ex_flag high exactly 1 cycle.
- mask=5'b00001, ex_req=5'b00001 -> no flag. Then mask_we with wdata=0 and ex_req=5'b00001 in the same cycle -> no flag. ex_req=5'b00001 the next cycle -> flag.
- In HANDLER, 20 cycles of ex_req=5'b01000 with ex_valid=1 -> drop_cnt saturates at 15, lost_vec=5'b01000, epc unchanged. eret -> IDLE, drop_cnt=0, lost_vec=0.
- eret in IDLE -> no change. eret with a simultaneous hit in HANDLER -> hit dropped, drop_cnt+1, then cleared by the return. A hit on the following cycle -> taken.
- rst asserted mid-HANDLER -> next cycle busy=0, epc=0, mask=MASK_RST, drop_cnt=0.
